tmds_link_sequencer: RTL and testbench

Pixel-clock-domain controller that sequences the three TMDS 10:1 DDR serializers of a DVI/HDMI transmitter. It owns the serializer reset release and schedules the 10-bit symbol presented to each lane every pixel clock. Depending on the video timing it presents control tokens, the HDMI video preamble and guard band, or pre-encoded video symbols. It sits between the per-lane TMDS encoders and the serializer instances.

---
 rtl/tmds_pkg.sv | 15 +
 rtl/tmds_lookahead_delay.sv | 21 ++
 rtl/tmds_link_sequencer.sv | 75 +++++++
 tb/tb_tmds_link_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control/guard symbols, sequencer states and timing constants.
package tmds_pkg;
  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] GB02  = 10'b1011001100;
  localparam logic [9:0] GB1   = 10'b0100110011;
  localparam int LOOKAHEAD = 10;
  localparam int PRE_LEN   = 8;
  typedef enum logic [2:0] {HOLD, CONTROL, PREAMBLE, GUARD, VIDEO} state_t;
  function automatic logic [9:0] ctl_tok(input logic [1:0] c);
    return c == 2'b00 ? TOK00 : c == 2'b01 ? TOK01 : c == 2'b10 ? TOK10 : TOK11;
  endfunction
endpackage

// File: rtl/tmds_lookahead_delay.sv
// tmds_lookahead_delay: fixed-depth shift register of timing and video symbols, cleared on reset.
module tmds_lookahead_delay
  import tmds_pkg::*;
#(
  parameter int DEPTH = LOOKAHEAD,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/tmds_link_sequencer.sv
// tmds_link_sequencer: serializer reset release and per-lane TMDS symbol scheduling.
// HDMI_GUARD_EN adds the 10-cycle lookahead, video preamble, guard band and short_blank.
module tmds_link_sequencer
  import tmds_pkg::*;
#(
  parameter int RST_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [9:0] vid0_sym,
  input  logic [9:0] vid1_sym,
  input  logic [9:0] vid2_sym,
  output logic [9:0] lane0_sym,
  output logic [9:0] lane1_sym,
  output logic [9:0] lane2_sym,
  output logic       serdes_rst,
  output logic       ready,
  output logic       short_blank
);
  state_t state, nxt;
  logic [7:0] cnt;
  logic d_de, d_hs, d_vs, rise, honour, sb_nxt;
  logic [9:0] d_v0, d_v1, d_v2;
`ifdef HDMI_GUARD_EN
  logic de_q;
  tmds_lookahead_delay #(.DEPTH(LOOKAHEAD), .W(33)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({de, hsync, vsync, vid0_sym, vid1_sym, vid2_sym}),
    .dout ({d_de, d_hs, d_vs, d_v0, d_v1, d_v2})
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) de_q <= 1'b0;
    else de_q <= de;
  assign rise = de & ~de_q;
`else
  assign {d_de, d_hs, d_vs, d_v0, d_v1, d_v2} = {de, hsync, vsync, vid0_sym, vid1_sym, vid2_sym};
  assign rise = 1'b0;
`endif
  // Lane registers load from the state being entered, so outputs track the state one-for-one.
  always_comb begin
    honour = state == CONTROL && rise && !d_de;
    sb_nxt = rise && state != HOLD && !honour;
    nxt = state;
    case (state)
      HOLD:     nxt = cnt == 8'(RST_HOLD - 1) ? CONTROL : HOLD;
      PREAMBLE: nxt = cnt == 8'(PRE_LEN - 1) ? GUARD : PREAMBLE;
      GUARD:    nxt = cnt == 8'd1 ? (d_de ? VIDEO : CONTROL) : GUARD;
      default:  nxt = honour ? PREAMBLE : d_de ? VIDEO : CONTROL;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= HOLD;
      cnt         <= '0;
      lane0_sym   <= TOK00;
      lane1_sym   <= TOK00;
      lane2_sym   <= TOK00;
      serdes_rst  <= 1'b1;
      ready       <= 1'b0;
      short_blank <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= nxt != state ? 8'd0 : cnt + 8'd1;
      lane0_sym   <= nxt == VIDEO ? d_v0 : nxt == GUARD ? GB02 : nxt == HOLD ? TOK00 : ctl_tok({d_vs, d_hs});
      lane1_sym   <= nxt == VIDEO ? d_v1 : nxt == GUARD ? GB1 : nxt == PREAMBLE ? TOK01 : TOK00;
      lane2_sym   <= nxt == VIDEO ? d_v2 : nxt == GUARD ? GB02 : TOK00;
      serdes_rst  <= nxt == HOLD;
      ready       <= nxt != HOLD;
      short_blank <= sb_nxt;
    end
endmodule

// File: tb/tb_tmds_link_sequencer.sv
// tb_tmds_link_sequencer: vector table, directed line sequences and random stimulus against a schedule model.
module tb_tmds_link_sequencer;
  localparam int RH = 4;
  localparam int NH = 4096;
`ifdef HDMI_GUARD_EN
  localparam bit HDMI = 1'b1;
  localparam int L = 10;
`else
  localparam bit HDMI = 1'b0;
  localparam int L = 0;
`endif
  localparam logic [9:0] T00 = 10'b1101010100, T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100, T11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100, G1 = 10'b0100110011;
  localparam logic [32:0] RSTV = {T00, T00, T00, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0, rst = 1'b0, de = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [9:0] vid0_sym = '0, vid1_sym = '0, vid2_sym = '0;
  logic [9:0] lane0_sym, lane1_sym, lane2_sym;
  logic serdes_rst, ready, short_blank;

  tmds_link_sequencer #(.RST_HOLD(RH)) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
    .vid0_sym(vid0_sym), .vid1_sym(vid1_sym), .vid2_sym(vid2_sym),
    .lane0_sym(lane0_sym), .lane1_sym(lane1_sym), .lane2_sym(lane2_sym),
    .serdes_rst(serdes_rst), .ready(ready), .short_blank(short_blank)
  );

  always #5 clk = ~clk;

  typedef enum int {C_NONE, C_HOLD, C_CTRL, C_PRE, C_GRD, C_VID} cat_t;
  typedef struct { logic hs; logic vs; logic [9:0] e0; } tok_vec_t;

  int total = 0, bad = 0;
  int cyc, edges;
  logic prev_de;
  cat_t cur;
  cat_t plan [NH+16];
  logic h_de [NH], h_hs [NH], h_vs [NH];
  logic [9:0] h_v0 [NH], h_v1 [NH], h_v2 [NH];
  logic [9:0] toks [4];
  logic [9:0] seen [$];
  int n_pre, n_grd, n_sb;

  task automatic check(input string nm, input logic [32:0] exp);
    logic [32:0] got;
    got = {lane0_sym, lane1_sym, lane2_sym, serdes_rst, ready, short_blank};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; edges = 0; prev_de = 1'b0; cur = C_HOLD;
    for (int i = 0; i < NH + 16; i++) plan[i] = C_NONE;
  endtask

  // Drive one input cycle, predict the outputs after the next edge, then compare.
  task automatic tick(input logic d, input logic hs, input logic vs, input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic dd, xh, xv, rise, hon, esb;
    logic [9:0] x0, x1, x2, e0, e1, e2;
    cat_t ec;
    de = d; hsync = hs; vsync = vs; vid0_sym = a; vid1_sym = b; vid2_sym = c;
    h_de[cyc] = d; h_hs[cyc] = hs; h_vs[cyc] = vs; h_v0[cyc] = a; h_v1[cyc] = b; h_v2[cyc] = c;
    edges++;
    if (cyc >= L) begin
      dd = h_de[cyc-L]; xh = h_hs[cyc-L]; xv = h_vs[cyc-L];
      x0 = h_v0[cyc-L]; x1 = h_v1[cyc-L]; x2 = h_v2[cyc-L];
    end else begin
      dd = 1'b0; xh = 1'b0; xv = 1'b0; x0 = '0; x1 = '0; x2 = '0;
    end
    rise = HDMI && d && !prev_de;
    hon = 1'b0;
    if (edges < RH) ec = C_HOLD;
    else if (plan[cyc] != C_NONE) ec = plan[cyc];
    else if (rise && cur == C_CTRL && !dd) begin
      hon = 1'b1;
      ec = C_PRE;
      for (int k = 1; k < 8; k++) plan[cyc+k] = C_PRE;
      plan[cyc+8] = C_GRD;
      plan[cyc+9] = C_GRD;
    end else ec = dd ? C_VID : C_CTRL;
    esb = rise && cur != C_HOLD && !hon;
    e0 = ec == C_VID ? x0 : ec == C_GRD ? G02 : ec == C_HOLD ? T00 : toks[{xv, xh}];
    e1 = ec == C_VID ? x1 : ec == C_GRD ? G1 : ec == C_PRE ? T01 : T00;
    e2 = ec == C_VID ? x2 : ec == C_GRD ? G02 : T00;
    prev_de = d; cur = ec;
    if (cyc < NH - 1) cyc++;
    @(negedge clk);
    check("model", {e0, e1, e2, ec == C_HOLD, ec != C_HOLD, esb});
  endtask

  task automatic obs(input int lim);
    if (lane0_sym < 10'(lim)) seen.push_back(lane0_sym);
    if (lane1_sym == T01) n_pre++;
    if (lane1_sym == G1) n_grd++;
    if (short_blank) n_sb++;
  endtask

  task automatic obs_clear();
    seen.delete(); n_pre = 0; n_grd = 0; n_sb = 0;
  endtask

  task automatic cmp_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic cmp_order(input string nm, input int n);
    int ok;
    ok = seen.size() == n;
    for (int i = 0; i < seen.size() && ok != 0; i++) ok = seen[i] == 10'(i);
    total++;
    if (ok == 0) begin
      bad++;
      $display("FAIL %s got %0d symbols (first=%0d) expected 0..%0d in order", nm, seen.size(), seen.size() > 0 ? int'(seen[0]) : -1, n - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    #1 check("rst_async", RSTV);
    @(negedge clk);
    check("rst_hold", RSTV);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tok_vec_t tv [4];
    int run;
    logic d;
    toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;
    tv[0] = '{hs: 1'b0, vs: 1'b0, e0: T00};
    tv[1] = '{hs: 1'b1, vs: 1'b0, e0: T01};
    tv[2] = '{hs: 1'b0, vs: 1'b1, e0: T10};
    tv[3] = '{hs: 1'b1, vs: 1'b1, e0: T11};
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    for (int k = 1; k <= RH + 1; k++) begin
      tick(1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0);
      if (k == RH - 1 || k == RH) begin
        total++;
        if ({ready, serdes_rst} !== {k >= RH, k < RH}) begin
          bad++;
          $display("FAIL rdy_edge k=%0d got=%b%b expected=%b%b", k, ready, serdes_rst, k >= RH, k < RH);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      repeat (L + 3) tick(1'b0, tv[i].hs, tv[i].vs, 10'($urandom), 10'($urandom), 10'($urandom));
      total++;
      if ({lane0_sym, lane1_sym, lane2_sym} !== {tv[i].e0, T00, T00}) begin
        bad++;
        $display("FAIL tok%0d got=%h/%h/%h expected=%h/%h/%h", i, lane0_sym, lane1_sym, lane2_sym, tv[i].e0, T00, T00);
      end
    end
    obs_clear();
    repeat (20) begin tick(1'b0, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 10'h3ff); obs(16); end
    for (int p = 0; p < 16; p++) begin tick(1'b1, 1'b0, 1'b0, 10'(p), 10'(p), 10'(p)); obs(16); end
    repeat (20) begin tick(1'b0, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 10'h3ff); obs(16); end
    cmp_order("line_order", 16);
    cmp_int("line_preamble", n_pre, HDMI ? 8 : 0);
    cmp_int("line_guard", n_grd, HDMI ? 2 : 0);
    obs_clear();
    repeat (20) begin tick(1'b0, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 10'h3ff); obs(32); end
    for (int p = 0; p < 16; p++) begin tick(1'b1, 1'b0, 1'b0, 10'(p), 10'(p), 10'(p)); obs(32); end
    repeat (4) begin tick(1'b0, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 10'h3ff); obs(32); end
    for (int p = 16; p < 32; p++) begin tick(1'b1, 1'b0, 1'b0, 10'(p), 10'(p), 10'(p)); obs(32); end
    repeat (20) begin tick(1'b0, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 10'h3ff); obs(32); end
    cmp_order("short_order", 32);
    cmp_int("short_pulses", n_sb, HDMI ? 1 : 0);
    cmp_int("short_guard", n_grd, HDMI ? 2 : 0);
    d = 1'b0;
    for (int n = 0; n < 600; n += run) begin
      run = int'($urandom_range(1, 24));
      d = ~d;
      repeat (run) tick(d, 1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    end
    repeat (20) tick(1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0);
    for (int p = 0; p < 15; p++) tick(1'b1, 1'b1, 1'b0, 10'(p + 100), 10'(p + 200), 10'(p + 300));
    do_reset();
    repeat (RH + 8) tick(1'b0, 1'($urandom), 1'($urandom), 10'h0, 10'h0, 10'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
